mem_access_ctrl: RTL

Memory-stage access sequencer for the pipelined MIPS core. It takes the decoded load/store operation, address and store data of the instruction in M. It drives a request/acknowledge data-memory port with byte enables, handles variable wait states and a timeout, and extends load data. It also holds the pipeline stalled until the access completes.

---
 rtl/mem_access_ctrl_pkg.sv | 39 +++
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl_load_ext.sv | 29 ++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access sequencer: op codes, FSM states, op helpers.
package mem_access_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LW   = 4'd1,
      OP_LH   = 4'd2,
      OP_LHU  = 4'd3,
      OP_LB   = 4'd4,
      OP_LBU  = 4'd5,
      OP_SW   = 4'd6,
      OP_SH   = 4'd7,
      OP_SB   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic op_is_load(input logic [3:0] op);
      return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return op inside {OP_SW, OP_SH, OP_SB};
   endfunction

   // Byte ops are always aligned; codes 9..15 never reach the alignment check.
   function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] lo);
      if (op inside {OP_LW, OP_SW})
         return lo == 2'b00;
      if (op inside {OP_LH, OP_LHU, OP_SH})
         return lo[0] == 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge data-memory port; master = access sequencer, slave = memory.
interface mem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl_load_ext.sv
// Load lane select and sign/zero extension of a read word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module load_ext
   import mem_access_ctrl_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? word[31:16] : word[15:0];
      data     = word;
      case (op)
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'd0, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'd0, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: drives the req/ack data port, extends loads, stalls the pipe.
// Latency: ack after N request cycles gives done on cycle N+1 and N+1 stall cycles.
// Backpressure: waits on mem_ack indefinitely up to TIMEOUT cycles, then aborts with bus_err.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   input  logic [3:0]          op,
   input  logic [31:0]         addr,
   input  logic [31:0]         wdata,
   input  logic                flush,
   mem_access_ctrl_if.master   mem,
   output logic                stall,
   output logic [31:0]         ld_data,
   output logic                done,
   output logic                addr_err,
   output logic                bus_err
);

   state_e      state;
   logic [7:0]  wait_cnt;
   logic [3:0]  op_r;
   logic [1:0]  lane_r;
   logic        mem_op_vld;
   logic        aligned;
   logic        accept;
   logic        misalign;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] ext_dat;

   assign mem_op_vld = op_valid & (op_is_load(op) | op_is_store(op)) & ~flush;
   assign aligned    = op_aligned(op, addr[1:0]);
   assign accept     = (state == ST_IDLE) & mem_op_vld & aligned;
   assign misalign   = (state == ST_IDLE) & mem_op_vld & ~aligned;
   assign stall      = accept | (state == ST_REQ);

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = wdata;
      case (op)
         OP_SH: begin
            be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{wdata[15:0]}};
         end
         OP_SB: begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{wdata[7:0]}};
         end
         default: ;
      endcase
   end

   load_ext u_load_ext (
      .op   (op_r),
      .lane (lane_r),
      .word (mem.mem_rdata),
      .data (ext_dat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         wait_cnt      <= 8'd0;
         op_r          <= 4'd0;
         lane_r        <= 2'd0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_be    <= 4'd0;
         mem.mem_addr  <= 32'd0;
         mem.mem_wdata <= 32'd0;
         ld_data       <= 32'd0;
         done          <= 1'b0;
         addr_err      <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         done     <= 1'b0;
         addr_err <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               addr_err <= misalign;
               if (accept) begin
                  state         <= ST_REQ;
                  wait_cnt      <= 8'd0;
                  op_r          <= op;
                  lane_r        <= addr[1:0];
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= op_is_store(op);
                  mem.mem_be    <= be_nxt;
                  mem.mem_addr  <= {addr[31:2], 2'b00};
                  mem.mem_wdata <= wdata_nxt;
               end
            end
            ST_REQ: begin
               // An ack on the final wait cycle takes priority over the timeout.
               if (mem.mem_ack) begin
                  state       <= ST_DONE;
                  mem.mem_req <= 1'b0;
                  done        <= 1'b1;
                  if (op_is_load(op_r))
                     ld_data <= ext_dat;
               end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                  state       <= ST_DONE;
                  mem.mem_req <= 1'b0;
                  done        <= 1'b1;
                  bus_err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
